// File: rtl/spi_slave_multimode.sv
// rtl/spi_slave_multimode.sv - SPI slave for all four modes with configurable width and bit order
module spi_slave_multimode #(
  parameter int WIDTH     = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit FILL_BIT  = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CS_i,
  input  logic             SCK_i,
  input  logic             MOSI_i,
  output logic             MISO_o,
  output logic             MISO_Enable_o,
  input  logic [WIDTH-1:0] TxData_i,
  input  logic             TxValid_i,
  output logic             TxReady_o,
  output logic [WIDTH-1:0] RxData_o,
  output logic             RxValid_o,
  output logic             TxUnderrun_o,
  output logic             Abort_o,
  output logic             Busy_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{FILL_BIT}};

  // [1] is the synchronised level, [2] the previous one for edge detection
  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;

  logic cs_active;
  logic cs_fall;
  logic cs_rise;
  logic sck_lead;
  logic sck_trail;
  logic sample_edge;
  logic shift_edge;
  logic load;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cs_q   <= 3'b111;
      sck_q  <= {3{CPOL}};
      mosi_q <= 2'b11;
    end else begin
      cs_q   <= {cs_q[1:0], CS_i};
      sck_q  <= {sck_q[1:0], SCK_i};
      mosi_q <= {mosi_q[0], MOSI_i};
    end
  end

  assign cs_active   = !cs_q[1];
  assign cs_fall     = cs_q[2] && !cs_q[1];
  assign cs_rise     = !cs_q[2] && cs_q[1];
  assign sck_lead    = cs_active && (sck_q[2] == CPOL) && (sck_q[1] != CPOL);
  assign sck_trail   = cs_active && (sck_q[2] != CPOL) && (sck_q[1] == CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead : sck_trail;
  // With CPHA=0 the first bit must be on MISO before the first edge, so CS fall loads
  assign load        = (!CPHA && cs_fall) || (shift_edge && (bit_cnt == '0));
  assign rx_next     = LSB_FIRST ? {mosi_q[1], rx_shift[WIDTH-1:1]}
                                 : {rx_shift[WIDTH-2:0], mosi_q[1]};

  assign Busy_o        = cs_active;
  assign MISO_Enable_o = cs_active;
  assign MISO_o        = cs_active && (LSB_FIRST ? tx_shift[0] : tx_shift[WIDTH-1]);
  assign TxReady_o     = !hold_full;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      bit_cnt      <= '0;
      tx_shift     <= FILL_WORD;
      rx_shift     <= '0;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      RxData_o     <= '0;
      RxValid_o    <= 1'b0;
      TxUnderrun_o <= 1'b0;
      Abort_o      <= 1'b0;
    end else begin
      RxValid_o    <= 1'b0;
      TxUnderrun_o <= 1'b0;
      Abort_o      <= 1'b0;
      if (cs_rise) begin
        bit_cnt <= '0;
        Abort_o <= (bit_cnt != '0);
      end else if (cs_fall) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt   <= '0;
          RxData_o  <= rx_next;
          RxValid_o <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (load) begin
        if (hold_full) begin
          tx_shift  <= hold_data;
          hold_full <= 1'b0;
        end else begin
          tx_shift     <= FILL_WORD;
          TxUnderrun_o <= 1'b1;
        end
      end else if (shift_edge) begin
        tx_shift <= LSB_FIRST ? {FILL_BIT, tx_shift[WIDTH-1:1]}
                              : {tx_shift[WIDTH-2:0], FILL_BIT};
      end
      // A write in the same cycle as a load lands after it: the load already saw empty
      if (TxValid_i && !hold_full) begin
        hold_data <= TxData_i;
        hold_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_multimode.sv
// tb/tb_spi_slave_multimode.sv - randomized bench for spi_slave_multimode across modes and widths
module tb_spi_slave_multimode;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Instances 0..3 are SPI modes 0..3 at WIDTH=8; instance 4 is mode 0, WIDTH=12, LSB first
  logic        cs[5], sck[5], mosi[5], txvalid[5];
  logic [11:0] txdata[5];
  logic        miso[5], men[5], txready[5], rxvalid[5], under[5], abrt[5], busy[5];
  logic [7:0]  rxd8[4];
  logic [11:0] rxd12;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_multimode #(.WIDTH(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)),
                          .LSB_FIRST(1'b0), .FILL_BIT(1'b1)) u_dut (
      .Clock(clk), .Reset(resetn), .CS_i(cs[g]), .SCK_i(sck[g]), .MOSI_i(mosi[g]),
      .MISO_o(miso[g]), .MISO_Enable_o(men[g]), .TxData_i(txdata[g][7:0]),
      .TxValid_i(txvalid[g]), .TxReady_o(txready[g]), .RxData_o(rxd8[g]),
      .RxValid_o(rxvalid[g]), .TxUnderrun_o(under[g]), .Abort_o(abrt[g]), .Busy_o(busy[g]));
  end

  spi_slave_multimode #(.WIDTH(12), .CPOL(1'b0), .CPHA(1'b0),
                        .LSB_FIRST(1'b1), .FILL_BIT(1'b1)) u_lsb (
    .Clock(clk), .Reset(resetn), .CS_i(cs[4]), .SCK_i(sck[4]), .MOSI_i(mosi[4]),
    .MISO_o(miso[4]), .MISO_Enable_o(men[4]), .TxData_i(txdata[4]),
    .TxValid_i(txvalid[4]), .TxReady_o(txready[4]), .RxData_o(rxd12),
    .RxValid_o(rxvalid[4]), .TxUnderrun_o(under[4]), .Abort_o(abrt[4]), .Busy_o(busy[4]));

  int checks = 0;
  int errors = 0;

  // strobe counters and received-word log, sampled on the falling clock edge
  int          rxv_cnt[5] = '{default: 0};
  int          und_cnt[5] = '{default: 0};
  int          abt_cnt[5] = '{default: 0};
  logic [11:0] rx_log[5][16];

  function automatic logic [11:0] rxdata_of(input int k);
    if (k == 4) return rxd12;
    return {4'h0, rxd8[k]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (rxvalid[k] === 1'b1) begin
        rx_log[k][rxv_cnt[k] % 16] <= rxdata_of(k);
        rxv_cnt[k] <= rxv_cnt[k] + 1;
      end
      if (under[k] === 1'b1) und_cnt[k] <= und_cnt[k] + 1;
      if (abrt[k] === 1'b1) abt_cnt[k] <= abt_cnt[k] + 1;
    end
  end

  function automatic int width_of(input int k);
    return (k == 4) ? 12 : 8;
  endfunction
  function automatic logic cpol_of(input int k);
    return (k == 2) || (k == 3);
  endfunction
  function automatic logic cpha_of(input int k);
    return (k == 1) || (k == 3);
  endfunction
  function automatic logic [11:0] mask_of(input int k);
    return (k == 4) ? 12'hFFF : 12'h0FF;
  endfunction

  // reference model: one-deep holding register and expectations for the last frame
  logic        hold_full_m[5] = '{default: 1'b0};
  logic [11:0] hold_word_m[5];
  logic [11:0] mo_words[4], mi_words[4], e_miso[4];
  int          e_rx, e_und, e_abt, base_rx, base_und, base_abt;

  logic [11:0] tx_vec[5] = '{12'h0A5, 12'h0C3, 12'h0C3, 12'h0C3, 12'h801};
  logic [11:0] rx_vec[5] = '{12'h03C, 12'h05A, 12'h05A, 12'h05A, 12'h00F};

  task automatic write_tx(input int k, input logic [11:0] d);
    txdata[k]  = d;
    txvalid[k] = 1'b1;
    @(negedge clk);
    txvalid[k] = 1'b0;
    @(negedge clk);
    hold_full_m[k] = 1'b1;
    hold_word_m[k] = d & mask_of(k);
  endtask

  // Master side: drives 'total' bits from mo_words, captures MISO at each master sample point.
  task automatic run_frame(input int k, input int total);
    int w, done, started, loads, bi, wd;
    logic cp, ch, lsb;
    w = width_of(k); cp = cpol_of(k); ch = cpha_of(k); lsb = (k == 4);
    done    = total / w;
    started = (total + w - 1) / w;
    // every word begins with a load; mode CPHA=0 also loads at CS fall and after each full word
    loads   = ch ? started : 1 + done;
    for (int j = 0; j < 4; j++)
      e_miso[j] = (j == 0 && hold_full_m[k]) ? hold_word_m[k] : mask_of(k);
    e_und = loads - (hold_full_m[k] ? 1 : 0);
    e_rx  = done;
    e_abt = ((total % w) != 0) ? 1 : 0;
    hold_full_m[k] = 1'b0;
    base_rx = rxv_cnt[k]; base_und = und_cnt[k]; base_abt = abt_cnt[k];
    for (int j = 0; j < 4; j++) mi_words[j] = 12'h0;

    cs[k] = 1'b0;
    repeat (10) @(negedge clk);
    for (int b = 0; b < total; b++) begin
      wd = b / w;
      bi = lsb ? (b % w) : (w - 1 - (b % w));
      if (!ch) begin
        mosi[k] = mo_words[wd][bi];
        repeat (5) @(negedge clk);
        mi_words[wd][bi] = miso[k];
        sck[k] = ~cp;
        repeat (5) @(negedge clk);
        sck[k] = cp;
      end else begin
        sck[k]  = ~cp;
        mosi[k] = mo_words[wd][bi];
        repeat (5) @(negedge clk);
        mi_words[wd][bi] = miso[k];
        sck[k] = cp;
        repeat (5) @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);
    cs[k]   = 1'b1;
    mosi[k] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if ({miso[k], men[k], txready[k], rxvalid[k], under[k], abrt[k], busy[k]} !== 7'b0010000) begin
          errors++;
          $display("FAIL reset_outputs k=%0d phase=%0d got %b exp 0010000", k, p,
                   {miso[k], men[k], txready[k], rxvalid[k], under[k], abrt[k], busy[k]});
        end
        checks++;
        if (rxdata_of(k) !== 12'h0) begin
          errors++;
          $display("FAIL reset_rxdata k=%0d got %h exp 000", k, rxdata_of(k));
        end
      end
      resetn = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_modes();
    logic [11:0] m;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < 4; r++) begin
        m = mask_of(k);
        mo_words[0] = (r == 0) ? rx_vec[k] : (12'($urandom) & m);
        if (r == 0) write_tx(k, tx_vec[k]);
        else if ($urandom_range(0, 3) != 0) write_tx(k, 12'($urandom) & m);
        run_frame(k, width_of(k));
        checks++;
        if (rxv_cnt[k] - base_rx !== e_rx) begin
          errors++; $display("FAIL modes_rxvalid k=%0d r=%0d got %0d exp %0d", k, r, rxv_cnt[k] - base_rx, e_rx);
        end
        checks++;
        if (und_cnt[k] - base_und !== e_und) begin
          errors++; $display("FAIL modes_underrun k=%0d r=%0d got %0d exp %0d", k, r, und_cnt[k] - base_und, e_und);
        end
        checks++;
        if (abt_cnt[k] - base_abt !== e_abt) begin
          errors++; $display("FAIL modes_abort k=%0d r=%0d got %0d exp %0d", k, r, abt_cnt[k] - base_abt, e_abt);
        end
        checks++;
        if (mi_words[0] !== e_miso[0]) begin
          errors++; $display("FAIL modes_miso k=%0d r=%0d got %h exp %h", k, r, mi_words[0], e_miso[0]);
        end
        checks++;
        if (rxdata_of(k) !== mo_words[0]) begin
          errors++; $display("FAIL modes_rxdata k=%0d r=%0d got %h exp %h", k, r, rxdata_of(k), mo_words[0]);
        end
        checks++;
        if ({txready[k], men[k]} !== {~hold_full_m[k], 1'b0}) begin
          errors++; $display("FAIL modes_idle k=%0d r=%0d got %b exp %b", k, r, {txready[k], men[k]}, {~hold_full_m[k], 1'b0});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ks[2] = '{1, 0};
    int k;
    for (int t = 0; t < 2; t++) begin
      k = ks[t];
      mo_words[0] = 12'($urandom) & mask_of(k);
      mo_words[1] = 12'($urandom) & mask_of(k);
      write_tx(k, 12'($urandom) & mask_of(k));
      run_frame(k, 2 * width_of(k));
      checks++;
      if (rxv_cnt[k] - base_rx !== 2) begin
        errors++; $display("FAIL b2b_rxvalid k=%0d got %0d exp 2", k, rxv_cnt[k] - base_rx);
      end
      checks++;
      if (und_cnt[k] - base_und !== e_und) begin
        errors++; $display("FAIL b2b_underrun k=%0d got %0d exp %0d", k, und_cnt[k] - base_und, e_und);
      end
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (mi_words[j] !== e_miso[j]) begin
          errors++; $display("FAIL b2b_miso k=%0d word=%0d got %h exp %h", k, j, mi_words[j], e_miso[j]);
        end
        checks++;
        if (rx_log[k][(base_rx + j) % 16] !== mo_words[j]) begin
          errors++; $display("FAIL b2b_rxword k=%0d word=%0d got %h exp %h", k, j, rx_log[k][(base_rx + j) % 16], mo_words[j]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [11:0] keep;
    keep = rxdata_of(0);
    mo_words[0] = 12'($urandom) & 12'h0FF;
    run_frame(0, 5);
    checks++;
    if (abt_cnt[0] - base_abt !== 1) begin
      errors++; $display("FAIL abort_pulse got %0d exp 1", abt_cnt[0] - base_abt);
    end
    checks++;
    if (rxv_cnt[0] - base_rx !== 0) begin
      errors++; $display("FAIL abort_rxvalid got %0d exp 0", rxv_cnt[0] - base_rx);
    end
    checks++;
    if (und_cnt[0] - base_und !== e_und) begin
      errors++; $display("FAIL abort_underrun got %0d exp %0d", und_cnt[0] - base_und, e_und);
    end
    checks++;
    if (rxdata_of(0) !== keep) begin
      errors++; $display("FAIL abort_rxdata_kept got %h exp %h", rxdata_of(0), keep);
    end
    mo_words[0] = 12'($urandom) & 12'h0FF;
    write_tx(0, 12'($urandom) & 12'h0FF);
    run_frame(0, 8);
    checks++;
    if (rxdata_of(0) !== mo_words[0] || rxv_cnt[0] - base_rx !== 1) begin
      errors++; $display("FAIL abort_next_rx got %h/%0d exp %h/1", rxdata_of(0), rxv_cnt[0] - base_rx, mo_words[0]);
    end
    checks++;
    if (mi_words[0] !== e_miso[0] || abt_cnt[0] - base_abt !== 0) begin
      errors++; $display("FAIL abort_next_tx got %h/%0d exp %h/0", mi_words[0], abt_cnt[0] - base_abt, e_miso[0]);
    end
  endtask

  task automatic test_reset_mid();
    int snap_rx[5], snap_und[5], snap_abt[5];
    write_tx(0, 12'($urandom) & 12'h0FF);
    cs[0] = 1'b0;
    repeat (10) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      mosi[0] = 1'($urandom);
      repeat (5) @(negedge clk);
      sck[0] = 1'b1;
      repeat (5) @(negedge clk);
      sck[0] = 1'b0;
    end
    sck[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      snap_rx[k] = rxv_cnt[k]; snap_und[k] = und_cnt[k]; snap_abt[k] = abt_cnt[k];
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({miso[k], men[k], txready[k], rxvalid[k], under[k], abrt[k], busy[k]} !== 7'b0010000) begin
        errors++;
        $display("FAIL midreset_outputs k=%0d got %b exp 0010000", k,
                 {miso[k], men[k], txready[k], rxvalid[k], under[k], abrt[k], busy[k]});
      end
      hold_full_m[k] = 1'b0;
    end
    cs[0]  = 1'b1;
    sck[0] = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rxv_cnt[k] !== snap_rx[k] || und_cnt[k] !== snap_und[k] || abt_cnt[k] !== snap_abt[k]) begin
        errors++;
        $display("FAIL midreset_strobes k=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", k,
                 rxv_cnt[k], und_cnt[k], abt_cnt[k], snap_rx[k], snap_und[k], snap_abt[k]);
      end
    end
    mo_words[0] = 12'($urandom) & 12'h0FF;
    write_tx(0, 12'($urandom) & 12'h0FF);
    run_frame(0, 8);
    checks++;
    if (rxdata_of(0) !== mo_words[0] || rxv_cnt[0] - base_rx !== 1) begin
      errors++; $display("FAIL midreset_next_rx got %h/%0d exp %h/1", rxdata_of(0), rxv_cnt[0] - base_rx, mo_words[0]);
    end
    checks++;
    if (mi_words[0] !== e_miso[0] || und_cnt[0] - base_und !== e_und) begin
      errors++; $display("FAIL midreset_next_tx got %h/%0d exp %h/%0d", mi_words[0], und_cnt[0] - base_und, e_miso[0], e_und);
    end
  endtask

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cs[k] = 1'b1; sck[k] = cpol_of(k); mosi[k] = 1'b1;
      txvalid[k] = 1'b0; txdata[k] = 12'h0;
    end
    repeat (4) @(negedge clk);
    test_reset();
    test_modes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
